// File: rtl/simd_sign_mod_pipe.sv
`default_nettype none
// ============================================================================
// Module   : simd_sign_mod_pipe
// Brief    : Pipelined SIMD sign modifier (pass/abs/neg/nabs/copysign-lane0)
//            with valid/ready handshake, registered output and skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module simd_sign_mod_pipe #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [2:0]                in_mode,
  input  logic [LANES-1:0]          in_lane_mask,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_illegal,
  output logic [COUNT_W-1:0]        op_count
);

  localparam logic [2:0] c_MODE_PASS  = 3'd0;
  localparam logic [2:0] c_MODE_ABS   = 3'd1;
  localparam logic [2:0] c_MODE_NEG   = 3'd2;
  localparam logic [2:0] c_MODE_NABS  = 3'd3;
  localparam logic [2:0] c_MODE_COPY0 = 3'd4;

  // New sign bit for one enabled lane; reserved codes leave the sign alone.
  function automatic logic f_sign(input logic [2:0] mode, input logic s, input logic s0);
    logic r;
    r = s;
    case (mode)
      c_MODE_PASS:  r = s;
      c_MODE_ABS:   r = 1'b0;
      c_MODE_NEG:   r = ~s;
      c_MODE_NABS:  r = 1'b1;
      c_MODE_COPY0: r = s0;
      default:      r = s;
    endcase
    return r;
  endfunction

  // Output register (OR) and skid register (SK)
  logic                     r_or_valid;
  logic [LANES*DATA_W-1:0]  r_or_data;
  logic [TAG_W-1:0]         r_or_tag;
  logic                     r_or_illegal;
  logic                     r_sk_valid;
  logic [LANES*DATA_W-1:0]  r_sk_data;
  logic [TAG_W-1:0]         r_sk_tag;
  logic                     r_sk_illegal;
  logic [COUNT_W-1:0]       r_op_count;

  logic [LANES*DATA_W-1:0]  w_mod_data;
  logic [LANES-1:0]         w_new_sign;
  logic                     w_src_sign;
  logic                     w_illegal;
  logic                     w_counts;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_or_load;

  // Lane 0's original sign is the copysign source even when lane 0 is masked.
  assign w_src_sign = in_data[DATA_W-1];
  assign w_illegal  = (in_mode > c_MODE_COPY0);
  assign w_counts   = (in_mode != c_MODE_PASS) && !w_illegal;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_new_sign[gi] = in_lane_mask[gi]
                            ? f_sign(in_mode, in_data[gi*DATA_W + DATA_W-1], w_src_sign)
                            : in_data[gi*DATA_W + DATA_W-1];
      assign w_mod_data[gi*DATA_W +: DATA_W] =
        {w_new_sign[gi], in_data[gi*DATA_W +: DATA_W-1]};
    end
  endgenerate

  // Ready depends only on registered state plus flush/rst, never on out_ready.
  assign in_ready   = !r_sk_valid && !flush && !rst;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_or_valid && out_ready;
  // OR can take a new beat when it is empty or being drained this edge.
  assign w_or_load  = !r_or_valid || w_out_fire;

  // Output register: refill from SK first (ordering), else from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_or_valid   <= 1'b0;
      r_or_data    <= '0;
      r_or_tag     <= '0;
      r_or_illegal <= 1'b0;
    end else if (flush) begin
      r_or_valid   <= 1'b0;
    end else if (w_or_load) begin
      if (r_sk_valid) begin
        r_or_valid   <= 1'b1;
        r_or_data    <= r_sk_data;
        r_or_tag     <= r_sk_tag;
        r_or_illegal <= r_sk_illegal;
      end else if (w_in_fire) begin
        r_or_valid   <= 1'b1;
        r_or_data    <= w_mod_data;
        r_or_tag     <= in_tag;
        r_or_illegal <= w_illegal;
      end else begin
        r_or_valid   <= 1'b0;
      end
    end
  end

  // Skid register: captures a beat accepted while OR is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sk_valid   <= 1'b0;
      r_sk_data    <= '0;
      r_sk_tag     <= '0;
      r_sk_illegal <= 1'b0;
    end else if (flush) begin
      r_sk_valid   <= 1'b0;
    end else if (w_or_load) begin
      r_sk_valid   <= 1'b0;
    end else if (w_in_fire) begin
      r_sk_valid   <= 1'b1;
      r_sk_data    <= w_mod_data;
      r_sk_tag     <= in_tag;
      r_sk_illegal <= w_illegal;
    end
  end

  // Saturating count of accepted beats carrying a legal, non-pass mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_in_fire && w_counts && (r_op_count != {COUNT_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_valid   = r_or_valid;
  assign out_data    = r_or_data;
  assign out_tag     = r_or_tag;
  assign out_illegal = r_or_illegal;
  assign op_count    = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_simd_sign_mod_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_sign_mod_pipe
// Brief    : Directed self-checking bench for simd_sign_mod_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_sign_mod_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [2:0]   in_mode = '0;
  logic [3:0]   in_lane_mask = '0;
  logic [5:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [5:0]   out_tag;
  logic         out_illegal;
  logic [15:0]  op_count;

  // Saturation instance with a 4-bit counter
  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic         s_out_valid;
  logic [127:0] s_out_data;
  logic [5:0]   s_out_tag;
  logic         s_out_illegal;
  logic [3:0]   s_op_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  simd_sign_mod_pipe u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_lane_mask(in_lane_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal), .op_count(op_count)
  );

  simd_sign_mod_pipe #(.COUNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(128'h0),
    .in_mode(3'd2), .in_lane_mask(4'hF), .in_tag(6'd0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .out_tag(s_out_tag), .out_illegal(s_out_illegal), .op_count(s_op_count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge (out_ready high, stage idle).
  task automatic send_one(input logic [127:0] d, input logic [2:0] m,
                          input logic [3:0] mask, input logic [5:0] t);
    in_data = d; in_mode = m; in_lane_mask = mask; in_tag = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  function automatic logic [127:0] pat(input int t);
    logic [7:0] b;
    b = t[7:0];
    return {16{b}};
  endfunction

  initial begin
    logic [5:0]   expq[$];
    logic [5:0]   exp_tag;
    logic [127:0] prev_d;
    logic [5:0]   prev_t;
    logic         stall_prev;
    int           held, sent, got;

    // ---------------- reset state ----------------
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // ---------------- ABS, all lanes ----------------
    send_one({32'h7FC00000, 32'h80000000, 32'h3F800000, 32'hBF800000}, 3'd1, 4'hF, 6'd1);
    chk("abs_valid", out_valid, 1'b1);
    chk("abs_data", out_data, {32'h7FC00000, 32'h00000000, 32'h3F800000, 32'h3F800000});
    chk("abs_illegal", out_illegal, 1'b0);
    chk("abs_count", op_count, 16'd1);

    // ---------------- NEG, mask 0101 ----------------
    send_one({32'h7FC00000, 32'h80000000, 32'h3F800000, 32'hBF800000}, 3'd2, 4'b0101, 6'd2);
    chk("neg_data", out_data, {32'h7FC00000, 32'h00000000, 32'h3F800000, 32'h3F800000});
    chk("neg_tag", out_tag, 6'd2);
    chk("neg_count", op_count, 16'd2);

    // ---------------- COPYSIGN0 ----------------
    send_one({32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'hC0000000}, 3'd4, 4'hF, 6'd3);
    chk("cps_data", out_data, {32'hFF7FFFFF, 32'h80000001, 32'hBF800000, 32'hC0000000});
    chk("cps_count", op_count, 16'd3);

    // COPYSIGN0 with lane 0 masked still sources lane 0's sign
    send_one({32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'hC0000000}, 3'd4, 4'b1110, 6'd4);
    chk("cps_mask_data", out_data, {32'hFF7FFFFF, 32'h80000001, 32'hBF800000, 32'hC0000000});

    // ---------------- reserved mode ----------------
    send_one({32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'hC0000000}, 3'd6, 4'hF, 6'd5);
    chk("rsv_data", out_data, {32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'hC0000000});
    chk("rsv_illegal", out_illegal, 1'b1);
    chk("rsv_count", op_count, 16'd4);
    tick();
    chk("idle_out_valid", out_valid, 1'b0);

    // ---------------- backpressure stream, tags 1..8 ----------------
    held = 0; sent = 1; got = 0; stall_prev = 1'b0;
    prev_d = '0; prev_t = '0;
    for (int c = 1; c <= 40 && got < 8; c++) begin
      if (stall_prev) begin
        chk("stall_data", out_data, prev_d);
        chk("stall_tag", out_tag, prev_t);
      end
      out_ready    = !(c >= 2 && c <= 4);
      in_valid     = (sent <= 8);
      in_tag       = sent[5:0];
      in_data      = pat(sent);
      in_mode      = 3'd0;
      in_lane_mask = 4'hF;
      #1;
      chk("bp_in_ready", in_ready, (held != 2));
      chk("bp_out_valid", out_valid, (held > 0));
      if (out_valid && out_ready) begin
        if (expq.size() > 0) begin
          exp_tag = expq.pop_front();
          chk("bp_tag", out_tag, exp_tag);
          chk("bp_data", out_data, pat(int'(exp_tag)));
        end else begin
          chk("bp_extra_beat", 1'b1, 1'b0);
        end
        got++;
        held--;
      end
      if (in_valid && in_ready) begin
        expq.push_back(sent[5:0]);
        sent++;
        held++;
      end
      stall_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_t = out_tag;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_beats_out", got, 8);
    chk("bp_count", op_count, 16'd4);

    // ---------------- flush with OR and SK full ----------------
    out_ready = 1'b0;
    send_one(128'h0, 3'd2, 4'hF, 6'h11);
    send_one(128'h0, 3'd2, 4'hF, 6'h12);
    chk("fl_sk_full", in_ready, 1'b0);
    chk("fl_count_pre", op_count, 16'd6);
    flush = 1'b1; in_valid = 1'b1; in_tag = 6'h13; in_mode = 3'd2;
    #1;
    chk("fl_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready_after", in_ready, 1'b1);
    chk("fl_count", op_count, 16'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_emit", out_valid, 1'b0);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    in_data = 128'h0; in_mode = 3'd2; in_lane_mask = 4'hF; in_tag = 6'h21;
    in_valid = 1'b1;
    tick();
    chk("ar_pre_valid", out_valid, 1'b1);
    chk("ar_pre_count", op_count, 16'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_op_count", op_count, 16'd0);
    chk("ar_out_data", out_data, 128'h0);
    chk("ar_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("ar_rel_in_ready", in_ready, 1'b1);
    tick();
    chk("ar_no_partial", out_valid, 1'b0);

    // ---------------- op_count saturation (COUNT_W=4) ----------------
    s_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) chk("sat_neg_data", s_out_data, {4{32'h80000000}});
      if (i == 14) chk("sat_at_15", s_op_count, 4'd15);
    end
    s_in_valid = 1'b0;
    tick();
    chk("sat_hold", s_op_count, 4'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
